alu_seq_ctrl: RTL



---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_div_iter.sv | 78 +++++++
 rtl/alu_seq_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: one-hot op codes, FSM state encoding
// and the quotient returned for a divide by zero.
package alu_pkg;

  localparam logic [12:0] OP_ADD  = 13'd1;
  localparam logic [12:0] OP_SUB  = 13'd2;
  localparam logic [12:0] OP_XOR  = 13'd4;
  localparam logic [12:0] OP_OR   = 13'd8;
  localparam logic [12:0] OP_AND  = 13'd16;
  localparam logic [12:0] OP_SLL  = 13'd32;
  localparam logic [12:0] OP_SRL  = 13'd64;
  localparam logic [12:0] OP_SRA  = 13'd128;
  localparam logic [12:0] OP_SLT  = 13'd256;
  localparam logic [12:0] OP_SLTU = 13'd512;
  localparam logic [12:0] OP_MUL  = 13'd1024;
  localparam logic [12:0] OP_DIV  = 13'd2048;
  localparam logic [12:0] OP_REM  = 13'd4096;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [63:0] DIV0_QUOT = 64'h0000_0000_FFFF_FFFF;

endpackage

// File: rtl/alu_div_iter.sv
// Restoring unsigned divider, one quotient bit per cycle; the first bit resolves on the
// start cycle so o_done rises XLEN-1 cycles after the start edge. i_clear aborts the run.
module alu_div_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_clear,
  input  logic            i_start,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_done,
  output logic [XLEN-1:0] o_quot,
  output logic [XLEN-1:0] o_rem
);

  localparam int CW = $clog2(XLEN + 1);

  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_quot;
  logic [XLEN-1:0] r_dsr;
  logic [CW-1:0]   r_cnt;
  logic            r_run;

  logic [XLEN-1:0] w_rem_cur;
  logic [XLEN-1:0] w_dvd_cur;
  logic [XLEN-1:0] w_dsr_cur;
  logic [XLEN:0]   w_trial;
  logic [XLEN-1:0] w_diff;
  logic            w_ge;
  logic [XLEN-1:0] w_rem_nxt;
  logic [XLEN-1:0] w_quot_nxt;

  // r_quot doubles as the dividend shift register: dividend bits leave at the top
  // while quotient bits enter at the bottom.
  always_comb begin
    w_rem_cur  = i_start ? '0  : r_rem;
    w_dvd_cur  = i_start ? i_a : r_quot;
    w_dsr_cur  = i_start ? i_b : r_dsr;
    w_trial    = {w_rem_cur, w_dvd_cur[XLEN-1]};
    w_ge       = (w_trial >= {1'b0, w_dsr_cur});
    w_diff     = w_trial[XLEN-1:0] - w_dsr_cur;
    w_rem_nxt  = w_ge ? w_diff : w_trial[XLEN-1:0];
    w_quot_nxt = {w_dvd_cur[XLEN-2:0], w_ge};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem  <= '0;
      r_quot <= '0;
      r_dsr  <= '0;
      r_cnt  <= '0;
      r_run  <= 1'b0;
    end else if (i_clear) begin
      r_cnt  <= '0;
      r_run  <= 1'b0;
    end else if (i_start) begin
      r_rem  <= w_rem_nxt;
      r_quot <= w_quot_nxt;
      r_dsr  <= i_b;
      r_cnt  <= CW'(XLEN - 1);
      r_run  <= 1'b1;
    end else if (r_run) begin
      if (r_cnt != '0) begin
        r_rem  <= w_rem_nxt;
        r_quot <= w_quot_nxt;
        r_cnt  <= r_cnt - 1'b1;
      end else begin
        r_run  <= 1'b0;
      end
    end
  end

  assign o_done = r_run && (r_cnt == '0);
  assign o_quot = r_quot;
  assign o_rem  = r_rem;

endmodule

// File: rtl/alu_seq_ctrl.sv
// One-op-in-flight ALU sequencer; latency 1 (simple ops), MUL_LAT (mul), XLEN+1 (div/rem, or 1
// with ALU_DIV_EARLY_EN when b==0 or a<b). Result held until out_ready; accepts while idle or draining.
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = 2,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [12:0]       in_op,
  input  logic [XLEN-1:0]   in_a,
  input  logic [XLEN-1:0]   in_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*XLEN-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag,
  output logic              busy
);

  localparam int SHW = $clog2(XLEN);

  state_t              r_state;
  logic                r_out_valid;
  logic [2*XLEN-1:0]   r_result;
  logic [TAG_W-1:0]    r_tag;
  logic [XLEN-1:0]     r_a;
  logic [XLEN-1:0]     r_b;
  logic                r_is_rem;
  logic [2:0]          r_mul_cnt;

  logic                w_accept;
  logic                w_is_mul;
  logic                w_is_div;
  logic                w_div_short;
  logic                w_div_start;
  logic                w_div_done;
  logic [XLEN-1:0]     w_div_quot;
  logic [XLEN-1:0]     w_div_rem;
  logic [SHW-1:0]      w_sh;
  logic [XLEN-1:0]     w_res32;
  logic [2*XLEN-1:0]   w_alu_res;
  logic [XLEN-1:0]     w_mul_a;
  logic [XLEN-1:0]     w_mul_b;
  logic [2*XLEN-1:0]   w_mul_prod;

  assign in_ready = rst_n && !flush &&
                    ((r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready));
  assign w_accept = in_valid && in_ready;
  assign w_is_mul = (in_op == OP_MUL);
  assign w_is_div = (in_op == OP_DIV) || (in_op == OP_REM);
  assign w_sh     = in_b[SHW-1:0];

`ifdef ALU_DIV_EARLY_EN
  logic [2*XLEN-1:0] w_short_res;
  assign w_div_short = (in_b == '0) || (in_a < in_b);
  assign w_short_res = (in_op == OP_REM) ? {{XLEN{1'b0}}, in_a} :
                       (in_b == '0)      ? (2*XLEN)'(DIV0_QUOT) : '0;
`else
  assign w_div_short = 1'b0;
`endif

  assign w_div_start = w_accept && w_is_div && !w_div_short;

  // Any op code that is not exactly one of the single-cycle encodings lands in default -> 0.
  always_comb begin
    w_res32 = '0;
    case (in_op)
      OP_ADD:  w_res32 = in_a + in_b;
      OP_SUB:  w_res32 = in_a - in_b;
      OP_XOR:  w_res32 = in_a ^ in_b;
      OP_OR:   w_res32 = in_a | in_b;
      OP_AND:  w_res32 = in_a & in_b;
      OP_SLL:  w_res32 = in_a << w_sh;
      OP_SRL:  w_res32 = in_a >> w_sh;
      OP_SRA:  w_res32 = $signed(in_a) >>> w_sh;
      OP_SLT:  w_res32 = {{(XLEN-1){1'b0}}, ($signed(in_a) < $signed(in_b))};
      OP_SLTU: w_res32 = {{(XLEN-1){1'b0}}, (in_a < in_b)};
      default: w_res32 = '0;
    endcase
    w_alu_res = {{XLEN{1'b0}}, w_res32};
  end

  // One shared multiplier: live operands when MUL_LAT==1, latched ones while counting.
  assign w_mul_a    = (r_state == ST_MUL) ? r_a : in_a;
  assign w_mul_b    = (r_state == ST_MUL) ? r_b : in_b;
  assign w_mul_prod = (2*XLEN)'(w_mul_a) * (2*XLEN)'(w_mul_b);

  alu_div_iter #(.XLEN(XLEN)) u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clear (flush),
    .i_start (w_div_start),
    .i_a     (in_a),
    .i_b     (in_b),
    .o_done  (w_div_done),
    .o_quot  (w_div_quot),
    .o_rem   (w_div_rem)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_tag       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_is_rem    <= 1'b0;
      r_mul_cnt   <= '0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_mul_cnt   <= '0;
    end else begin
      case (r_state)
        ST_MUL: begin
          if (r_mul_cnt <= 3'd1) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_prod;
          end else begin
            r_mul_cnt   <= r_mul_cnt - 3'd1;
          end
        end
        ST_DIV: begin
          if (w_div_done) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= {{XLEN{1'b0}}, (r_is_rem ? w_div_rem : w_div_quot)};
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: ;
      endcase

      // An accept in DONE overrides the drain transition above.
      if (w_accept) begin
        r_a      <= in_a;
        r_b      <= in_b;
        r_tag    <= in_tag;
        r_is_rem <= (in_op == OP_REM);
        if (w_is_mul) begin
          if (MUL_LAT <= 1) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_mul_prod;
          end else begin
            r_state     <= ST_MUL;
            r_out_valid <= 1'b0;
            r_mul_cnt   <= 3'(MUL_LAT - 1);
          end
        end else if (w_is_div && !w_div_short) begin
          r_state     <= ST_DIV;
          r_out_valid <= 1'b0;
        end
`ifdef ALU_DIV_EARLY_EN
        else if (w_is_div) begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_short_res;
        end
`endif
        else begin
          r_state     <= ST_DONE;
          r_out_valid <= 1'b1;
          r_result    <= w_alu_res;
        end
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_result;
  assign out_tag    = r_tag;
  assign busy       = (r_state != ST_IDLE);

endmodule
